i2c_slave_reg_bank: RTL and testbench
=====================================

I2C_SLAVE_REG_BANK -- requirements
Module: i2c_slave_reg_bank

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, is the register index width; the bank holds 2**ADDR_WIDTH registers.
REQ-002 Parameter RESET_VALUE, default 8'h00, is the reset value of every register.
REQ-003 clock  input  1  system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 slv_data_read  input  8  byte received by the I2C slave.
REQ-006 slv_read_write_flag  input  1  slave direction: 1 = master reads, 0 = master writes.
REQ-007 slv_data_finish  input  1  one-cycle pulse per completed data byte.
REQ-008 slv_transfer_status  input  1  high while the slave is addressed.
REQ-009 slv_error  input  1  received-byte error, valid with slv_data_finish.
REQ-010 slv_data_write  output  8  byte for the slave to transmit.
REQ-011 host_addr  input  ADDR_WIDTH  local register index.
REQ-012 host_wr_en  input  1  local write strobe.
REQ-013 host_wr_data  input  8  local write data.
REQ-014 host_rd_data  output  8  registered contents of regs[host_addr].
REQ-015 reg_update  output  1  one-cycle pulse when I2C writes a register.
REQ-016 reg_update_addr  output  ADDR_WIDTH  index written, valid with reg_update.
REQ-017 host_wr_collision  output  1  one-cycle pulse when a host write is dropped.

Function
REQ-018 The transfer start is the rising edge of slv_transfer_status (sampled previous value 0, current value 1).
REQ-019 The FSM states are IDLE, GET_POINTER, WRITE_REGS and READ_REGS.
REQ-020 In IDLE, on a transfer start with slv_read_write_flag=0, the FSM enters GET_POINTER.
REQ-021 In IDLE, on a transfer start with slv_read_write_flag=1, the FSM enters READ_REGS and loads slv_data_write <= regs[ptr] in the same cycle.
REQ-022 From any non-IDLE state, slv_transfer_status=0 returns the FSM to IDLE; ptr is retained.
REQ-023 In GET_POINTER, slv_data_finish with slv_error=0 loads ptr <= slv_data_read[ADDR_WIDTH-1:0], ignores the upper bits, and moves the FSM to WRITE_REGS.
REQ-024 In WRITE_REGS, slv_data_finish with slv_error=0 writes regs[ptr] <= slv_data_read, sets ptr <= ptr+1 and pulses reg_update with reg_update_addr = old ptr on the next cycle.
REQ-025 In READ_REGS, slv_data_finish sets ptr <= ptr+1 and slv_data_write <= regs[ptr+1] in the same cycle.
REQ-026 slv_data_write changes only as stated in REQ-021 and REQ-025, so it stays stable during byte transmission.
REQ-027 ptr arithmetic is modulo 2**ADDR_WIDTH; the highest index increments to 0.
REQ-028 slv_data_finish with slv_error=1 in GET_POINTER or WRITE_REGS is discarded: no register, ptr or state change, and no reg_update.
REQ-029 host_wr_en writes regs[host_addr] <= host_wr_data on the next edge.
REQ-030 When a host write and an I2C write target the same index in the same cycle, the I2C write wins, the host write is dropped and host_wr_collision pulses.
REQ-031 Host and I2C writes to different indices in the same cycle both complete.
REQ-032 host_rd_data <= regs[host_addr] every cycle (1-cycle latency) and reflects a write made in cycle N from cycle N+2.
REQ-033 A same-cycle host write to regs[ptr] during READ_REGS with slv_data_finish is not visible in that cycle's slv_data_write load (old value is sent).

Reset
REQ-034 reset_n=0 immediately sets FSM=IDLE, ptr=0, all regs=RESET_VALUE, slv_data_write=RESET_VALUE, host_rd_data=RESET_VALUE, and reg_update, reg_update_addr and host_wr_collision to 0.
REQ-035 The sampled slv_transfer_status history register resets to 1, so a transfer already in progress at reset release is ignored until slv_transfer_status falls and rises again.

Verification
REQ-036 Master write: transfer start (flag=0), then bytes 0x03, 0xAA, 0xBB -> regs[3]=0xAA, regs[4]=0xBB, two reg_update pulses (addr 3, 4), ptr=5.
REQ-037 Master read after REQ-036 with a new write transaction that sets pointer 0x03, then a read transfer start -> slv_data_write=0xAA; after the first slv_data_finish it is 0xBB; after the second it is regs[5]=0x00.
REQ-038 Wrap: pointer 0x0F, write 0x11 and 0x22 -> regs[15]=0x11, regs[0]=0x22, ptr=1; pointer byte 0xF2 -> ptr=2.
REQ-039 Error: in WRITE_REGS, slv_data_finish with slv_error=1 and data 0x55 -> no register change, no reg_update, ptr unchanged.
REQ-040 Collision: host write 0x77 and I2C write 0x99 to index 4 in the same cycle -> regs[4]=0x99 and one host_wr_collision pulse; host writing index 5 in the same cycle -> regs[5] updated.
REQ-041 Reset mid-transfer: assert reset_n during WRITE_REGS with slv_transfer_status held high -> all registers RESET_VALUE, FSM stays IDLE with no writes until slv_transfer_status falls and rises again.

Source files
------------

// File: rtl/i2c_slave_reg_bank.sv
// Register bank behind an I2C slave byte interface.
// Pointer-addressed multi-byte access plus a local host port.
module i2c_slave_reg_bank #(
  parameter int          ADDR_WIDTH  = 4,
  parameter logic [7:0]  RESET_VALUE = 8'h00
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [7:0]            slv_data_read,
  input  logic                  slv_read_write_flag,
  input  logic                  slv_data_finish,
  input  logic                  slv_transfer_status,
  input  logic                  slv_error,
  output logic [7:0]            slv_data_write,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic                  host_wr_en,
  input  logic [7:0]            host_wr_data,
  output logic [7:0]            host_rd_data,
  output logic                  reg_update,
  output logic [ADDR_WIDTH-1:0] reg_update_addr,
  output logic                  host_wr_collision
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    GET_POINTER,
    WRITE_REGS,
    READ_REGS
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] ptr_nxt;
  logic [ADDR_WIDTH-1:0] ptr_inc;
  logic [7:0]            regs [DEPTH];
  logic [7:0]            dw_nxt;
  logic                  status_q;
  logic                  start;
  logic                  ok_byte;
  logic                  i2c_we;
  logic                  collision;
  logic                  host_we;

  assign start     = slv_transfer_status & ~status_q;
  assign ok_byte   = slv_data_finish & ~slv_error;
  assign ptr_inc   = ptr + ADDR_WIDTH'(1);
  assign collision = host_wr_en & i2c_we
                   & (host_addr == ptr);
  assign host_we   = host_wr_en & ~collision;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    i2c_we    = 1'b0;
    dw_nxt    = slv_data_write;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (slv_read_write_flag) begin
            state_nxt = READ_REGS;
            dw_nxt    = regs[ptr];
          end else begin
            state_nxt = GET_POINTER;
          end
        end
      end
      GET_POINTER: begin
        if (!slv_transfer_status) begin
          state_nxt = IDLE;
        end else if (ok_byte) begin
          ptr_nxt   = slv_data_read[ADDR_WIDTH-1:0];
          state_nxt = WRITE_REGS;
        end
      end
      WRITE_REGS: begin
        if (!slv_transfer_status) begin
          state_nxt = IDLE;
        end else if (ok_byte) begin
          i2c_we  = 1'b1;
          ptr_nxt = ptr_inc;
        end
      end
      READ_REGS: begin
        if (!slv_transfer_status) begin
          state_nxt = IDLE;
        end else if (slv_data_finish) begin
          ptr_nxt = ptr_inc;
          dw_nxt  = regs[ptr_inc];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // history resets high so a transfer live at reset release is ignored
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      ptr               <= '0;
      status_q          <= 1'b1;
      slv_data_write    <= RESET_VALUE;
      reg_update        <= 1'b0;
      reg_update_addr   <= '0;
      host_wr_collision <= 1'b0;
    end else begin
      state             <= state_nxt;
      ptr               <= ptr_nxt;
      status_q          <= slv_transfer_status;
      slv_data_write    <= dw_nxt;
      reg_update        <= i2c_we;
      reg_update_addr   <= i2c_we ? ptr : reg_update_addr;
      host_wr_collision <= collision;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= RESET_VALUE;
      end
      host_rd_data <= RESET_VALUE;
    end else begin
      if (host_we) begin
        regs[host_addr] <= host_wr_data;
      end
      if (i2c_we) begin
        regs[ptr] <= slv_data_read;
      end
      host_rd_data <= regs[host_addr];
    end
  end

endmodule

// File: tb/tb_i2c_slave_reg_bank.sv
// Scoreboard bench for i2c_slave_reg_bank.
// Transaction-level model drives expectation queues.
module tb_i2c_slave_reg_bank;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] slv_data_read;
  logic       slv_read_write_flag;
  logic       slv_data_finish;
  logic       slv_transfer_status;
  logic       slv_error;
  logic [7:0] slv_data_write;
  logic [3:0] host_addr;
  logic       host_wr_en;
  logic [7:0] host_wr_data;
  logic [7:0] host_rd_data;
  logic       reg_update;
  logic [3:0] reg_update_addr;
  logic       host_wr_collision;

  i2c_slave_reg_bank dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .slv_data_read       (slv_data_read),
    .slv_read_write_flag (slv_read_write_flag),
    .slv_data_finish     (slv_data_finish),
    .slv_transfer_status (slv_transfer_status),
    .slv_error           (slv_error),
    .slv_data_write      (slv_data_write),
    .host_addr           (host_addr),
    .host_wr_en          (host_wr_en),
    .host_wr_data        (host_wr_data),
    .host_rd_data        (host_rd_data),
    .reg_update          (reg_update),
    .reg_update_addr     (reg_update_addr),
    .host_wr_collision   (host_wr_collision)
  );

  always #5 clock = ~clock;

  int passed = 0;
  int total  = 0;

  logic [7:0] m_regs [16];
  int         m_ptr;
  bit         m_writing;
  bit         m_got_ptr;

  int         upd_q  [$];
  int         coll_q [$];
  logic [7:0] dq     [$];
  logic [7:0] hq     [$];
  logic       tx_strobe = 1'b0;
  logic       hr_strobe = 1'b0;

  function automatic void check(string name,
                                int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endfunction

  function automatic void unexpected(string name,
                                     int act);
    total++;
    $display("FAIL %s: got %0h expected none",
             name, act);
  endfunction

  // monitors: pop expectations whenever the DUT presents output
  always @(negedge clock) begin
    if (reg_update) begin
      if (upd_q.size() == 0)
        unexpected("reg_update", reg_update_addr);
      else
        check("reg_update_addr", reg_update_addr,
              upd_q.pop_front());
    end
    if (host_wr_collision) begin
      if (coll_q.size() == 0)
        unexpected("collision", 1);
      else
        check("collision", 1, coll_q.pop_front());
    end
    if (tx_strobe) begin
      if (dq.size() == 0) unexpected("tx", slv_data_write);
      else check("slv_data_write", slv_data_write,
                 dq.pop_front());
    end
    if (hr_strobe) begin
      if (hq.size() == 0) unexpected("hrd", host_rd_data);
      else check("host_rd_data", host_rd_data,
                 hq.pop_front());
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr     = 0;
    m_writing = 0;
    m_got_ptr = 0;
  endtask

  task automatic stop_xfer();
    slv_transfer_status = 1'b0;
    m_writing = 0;
    tick();
    tick();
  endtask

  task automatic wr_start();
    slv_read_write_flag = 1'b0;
    slv_transfer_status = 1'b1;
    tick();
    m_writing = 1;
    m_got_ptr = 0;
  endtask

  task automatic wr_byte(logic [7:0] b, bit err,
                         bit hen, int ha,
                         logic [7:0] hd);
    bit i2c_w;
    slv_data_read   = b;
    slv_error       = err;
    slv_data_finish = 1'b1;
    host_wr_en      = hen;
    host_addr       = 4'(ha);
    host_wr_data    = hd;
    tick();
    slv_data_finish = 1'b0;
    slv_error       = 1'b0;
    host_wr_en      = 1'b0;
    i2c_w = m_writing && m_got_ptr && !err;
    if (hen) begin
      if (i2c_w && ha == m_ptr) coll_q.push_back(1);
      else m_regs[ha] = hd;
    end
    if (i2c_w) begin
      m_regs[m_ptr] = b;
      upd_q.push_back(m_ptr);
      m_ptr = (m_ptr + 1) % 16;
    end else if (m_writing && !err) begin
      m_ptr     = b % 16;
      m_got_ptr = 1;
    end
    tick();
  endtask

  task automatic rd_txn(int n);
    slv_read_write_flag = 1'b1;
    slv_transfer_status = 1'b1;
    tick();
    dq.push_back(m_regs[m_ptr]);
    tx_strobe = 1'b1;
    tick();
    tx_strobe = 1'b0;
    for (int i = 0; i < n; i++) begin
      slv_data_finish = 1'b1;
      tick();
      slv_data_finish = 1'b0;
      m_ptr = (m_ptr + 1) % 16;
      dq.push_back(m_regs[m_ptr]);
      tx_strobe = 1'b1;
      tick();
      tx_strobe = 1'b0;
    end
    stop_xfer();
  endtask

  task automatic host_wr(int a, logic [7:0] d);
    host_addr    = 4'(a);
    host_wr_data = d;
    host_wr_en   = 1'b1;
    tick();
    host_wr_en = 1'b0;
    m_regs[a]  = d;
  endtask

  task automatic host_rd(int a);
    host_addr = 4'(a);
    tick();
    hq.push_back(m_regs[a]);
    hr_strobe = 1'b1;
    tick();
    hr_strobe = 1'b0;
  endtask

  task automatic wr_txn(logic [7:0] p,
                        logic [7:0] d0, logic [7:0] d1);
    wr_start();
    wr_byte(p, 0, 0, 0, 8'h00);
    wr_byte(d0, 0, 0, 0, 8'h00);
    wr_byte(d1, 0, 0, 0, 8'h00);
    stop_xfer();
  endtask

  initial begin
    reset_n             = 1'b0;
    slv_data_read       = 8'h00;
    slv_read_write_flag = 1'b0;
    slv_data_finish     = 1'b0;
    slv_transfer_status = 1'b0;
    slv_error           = 1'b0;
    host_addr           = 4'h0;
    host_wr_en          = 1'b0;
    host_wr_data        = 8'h00;
    model_reset();
    #12;
    check("rst_slv_data_write", slv_data_write, 0);
    check("rst_host_rd_data", host_rd_data, 0);
    check("rst_reg_update", reg_update, 0);
    check("rst_collision", host_wr_collision, 0);
    tick();
    reset_n = 1'b1;
    tick();
    tick();

    // master write then pointer-setting read-back
    wr_txn(8'h03, 8'hAA, 8'hBB);
    rd_txn(0);
    wr_start();
    wr_byte(8'h03, 0, 0, 0, 8'h00);
    stop_xfer();
    rd_txn(2);
    host_rd(3);
    host_rd(4);

    // wrap and upper pointer bits ignored
    wr_txn(8'h0F, 8'h11, 8'h22);
    host_rd(15);
    host_rd(0);
    rd_txn(0);
    wr_start();
    wr_byte(8'hF2, 0, 0, 0, 8'h00);
    stop_xfer();
    rd_txn(1);

    // errored bytes discarded in both write phases
    wr_start();
    wr_byte(8'h09, 1, 0, 0, 8'h00);
    wr_byte(8'h06, 0, 0, 0, 8'h00);
    wr_byte(8'h55, 1, 0, 0, 8'h00);
    stop_xfer();
    rd_txn(0);
    host_rd(6);

    // collision on index 4, then disjoint host write to 5
    wr_start();
    wr_byte(8'h04, 0, 0, 0, 8'h00);
    wr_byte(8'h99, 0, 1, 4, 8'h77);
    stop_xfer();
    host_rd(4);
    wr_start();
    wr_byte(8'h04, 0, 0, 0, 8'h00);
    wr_byte(8'h99, 0, 1, 5, 8'h66);
    stop_xfer();
    host_rd(4);
    host_rd(5);

    // reset in WRITE_REGS with the transfer held high
    wr_start();
    wr_byte(8'h02, 0, 0, 0, 8'h00);
    wr_byte(8'h5A, 0, 0, 0, 8'h00);
    reset_n = 1'b0;
    #2;
    check("mid_rst_data_write", slv_data_write, 0);
    check("mid_rst_host_rd", host_rd_data, 0);
    model_reset();
    tick();
    reset_n = 1'b1;
    tick();
    wr_byte(8'h07, 0, 0, 0, 8'h00);
    wr_byte(8'hC3, 0, 0, 0, 8'h00);
    stop_xfer();
    for (int i = 0; i < 16; i++) host_rd(i);
    rd_txn(1);

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 3))
        0: begin
          wr_start();
          wr_byte(8'($urandom), $urandom_range(0, 5) == 0,
                  0, 0, 8'h00);
          for (int k = $urandom_range(1, 4); k > 0; k--) begin
            bit hen;
            int ha;
            hen = $urandom_range(0, 2) == 0;
            ha  = $urandom_range(0, 1) ? m_ptr
                                       : $urandom_range(0, 15);
            wr_byte(8'($urandom), $urandom_range(0, 5) == 0,
                    hen, ha, 8'($urandom));
          end
          stop_xfer();
        end
        1: rd_txn($urandom_range(0, 4));
        2: host_wr($urandom_range(0, 15), 8'($urandom));
        default: host_rd($urandom_range(0, 15));
      endcase
    end
    for (int i = 0; i < 16; i++) host_rd(i);

    tick();
    tick();
    check("upd_q_drained", upd_q.size(), 0);
    check("coll_q_drained", coll_q.size(), 0);
    check("dq_drained", dq.size(), 0);
    check("hq_drained", hq.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
